// File: rtl/peridot_board_i2c_defs.sv
// Shared I2C PHY definitions: FSM encodings, frame bit limits, filtered-line record.
package peridot_board_i2c_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } i2c_state_e;

  // Counter value on entering the ACK slot, and the full frame length.
  localparam logic [3:0] BYTE_BITS  = 4'd8;
  localparam logic [3:0] FRAME_BITS = 4'd9;

  localparam int NUM_LINES = 2;
  localparam int LN_SDA    = 0;
  localparam int LN_SCL    = 1;

  // Filtered level plus one-cycle edge flags, coincident with the new level.
  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } line_t;

endpackage

// File: rtl/peridot_board_i2c_filter.sv
// Bus line conditioner: SYNC_STAGES-deep synchroniser followed by a stability
// filter that accepts a new level only after FILTER_LEN consecutive samples.
module peridot_board_i2c_filter
  import peridot_board_i2c_defs::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic  clock_sig,
  input  logic  reset_sig,
  input  logic  raw,
  output line_t line
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      sync_q <= '1;
      cnt_q  <= '0;
      line   <= '{lvl: 1'b1, rise: 1'b0, fall: 1'b0};
    end else begin
      sync_q    <= SYNC_STAGES'({sync_q, raw});
      line.rise <= 1'b0;
      line.fall <= 1'b0;
      // cnt_q counts consecutive samples disagreeing with the accepted level
      if (sample == line.lvl) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q <= '0;
        line  <= '{lvl: sample, rise: sample, fall: ~sample};
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/peridot_board_i2c_phy.sv
// I2C slave-side bit PHY: START/STOP detection, byte shift in/out, ACK slot
// handling with optional SCL stretching. All decisions use filtered levels.
module peridot_board_i2c_phy
  import peridot_board_i2c_defs::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_scl_o,
  output logic       i2c_sda_o,
  output logic       condi_start,
  output logic       condi_stop,
  output logic       done_byte,
  output logic [7:0] recieve_bytedata,
  input  logic       ackwaitrequest,
  output logic       done_ack,
  input  logic       send_ackdata,
  output logic       recieve_ackdata,
  input  logic [7:0] send_bytedata,
  input  logic       send_bytedatavalid
);

  logic [NUM_LINES-1:0] raw_lines;
  line_t [NUM_LINES-1:0] lines;
  line_t scl, sda;

  assign raw_lines[LN_SCL] = i2c_scl_i;
  assign raw_lines[LN_SDA] = i2c_sda_i;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_filt
    peridot_board_i2c_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_filt (
      .clock_sig(clock_sig),
      .reset_sig(reset_sig),
      .raw      (raw_lines[g]),
      .line     (lines[g])
    );
  end

  assign scl = lines[LN_SCL];
  assign sda = lines[LN_SDA];

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, cnt_inc;
  logic [7:0] rx_sh_q, tx_sh_q;
  logic       armed_q, tx_q, hold_en_q;
  logic       start_det, stop_det, counted_fall, byte_end, frame_end;

  assign start_det    = sda.fall & scl.lvl;
  assign stop_det     = sda.rise & scl.lvl;
  // The SCL fall that ends the START hold is not a bit boundary.
  assign counted_fall = scl.fall & armed_q;
  assign cnt_inc      = bit_cnt_q + 4'd1;

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    byte_end  = 1'b0;
    frame_end = 1'b0;
    i2c_sda_o = 1'b1;
    i2c_scl_o = 1'b1;
    unique case (state_q)
      ST_IDLE: ;
      ST_DATA: if (counted_fall && cnt_inc == BYTE_BITS) begin
        state_d  = ST_ACK;
        byte_end = 1'b1;
      end
      ST_ACK: if (counted_fall && cnt_inc == FRAME_BITS) begin
        state_d   = ST_DATA;
        frame_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_det || stop_det) begin
      state_d   = start_det ? ST_DATA : ST_IDLE;
      byte_end  = 1'b0;
      frame_end = 1'b0;
    end else begin
      if (state_q == ST_ACK && !tx_q)      i2c_sda_o = ~send_ackdata;
      else if (state_q == ST_DATA && tx_q) i2c_sda_o = tx_sh_q[7];
      // Stretch only in the low phase before the 9th rise.
      if (state_q == ST_ACK && hold_en_q && !done_byte && ackwaitrequest && !scl.lvl)
        i2c_scl_o = 1'b0;
    end
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      bit_cnt_q        <= '0;
      rx_sh_q          <= '0;
      tx_sh_q          <= '1;
      armed_q          <= 1'b0;
      tx_q             <= 1'b0;
      hold_en_q        <= 1'b0;
      condi_start      <= 1'b0;
      condi_stop       <= 1'b0;
      done_byte        <= 1'b0;
      done_ack         <= 1'b0;
      recieve_bytedata <= '0;
      recieve_ackdata  <= 1'b0;
    end else begin
      condi_start <= start_det;
      condi_stop  <= stop_det;
      done_byte   <= byte_end;
      done_ack    <= frame_end;
      if (start_det || stop_det) begin
        bit_cnt_q <= '0;
        armed_q   <= 1'b0;
        tx_q      <= 1'b0;
        hold_en_q <= 1'b0;
      end else begin
        if (scl.rise && state_q != ST_IDLE) armed_q <= 1'b1;
        if (scl.rise && state_q == ST_DATA) rx_sh_q <= {rx_sh_q[6:0], sda.lvl};
        if (scl.rise && state_q == ST_ACK) begin
          recieve_ackdata <= ~sda.lvl;
          hold_en_q       <= 1'b0;
        end
        if (byte_end) begin
          recieve_bytedata <= rx_sh_q;
          bit_cnt_q        <= cnt_inc;
          hold_en_q        <= 1'b1;
        end else if (frame_end) begin
          bit_cnt_q <= '0;
          tx_q      <= 1'b0;
          hold_en_q <= 1'b0;
        end else if (counted_fall && state_q == ST_DATA) begin
          bit_cnt_q <= cnt_inc;
          if (tx_q) tx_sh_q <= {tx_sh_q[6:0], 1'b1};
        end
        // Next-byte decision is taken while done_ack is visible to the user.
        if (done_ack) begin
          tx_q <= send_bytedatavalid;
          if (send_bytedatavalid) tx_sh_q <= send_bytedata;
        end
      end
    end
  end

endmodule

// File: tb/tb_peridot_board_i2c_phy.sv
// Directed bench: a bus-level I2C master drives the PHY through open-drain wiring.
module tb_peridot_board_i2c_phy;

  localparam int H = 16;

  logic       clock_sig = 1'b0;
  logic       reset_sig = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       i2c_scl_o, i2c_sda_o, condi_start, condi_stop, done_byte, done_ack;
  logic [7:0] recieve_bytedata;
  logic       recieve_ackdata;
  logic       ackwaitrequest = 1'b0, send_ackdata = 1'b0, send_bytedatavalid = 1'b0;
  logic [7:0] send_bytedata = 8'h00;

  always #5 clock_sig = ~clock_sig;

  assign scl_bus = m_scl & i2c_scl_o;
  assign sda_bus = m_sda & i2c_sda_o;

  peridot_board_i2c_phy #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clock_sig         (clock_sig),
    .reset_sig         (reset_sig),
    .i2c_scl_i         (scl_bus),
    .i2c_sda_i         (sda_bus),
    .i2c_scl_o         (i2c_scl_o),
    .i2c_sda_o         (i2c_sda_o),
    .condi_start       (condi_start),
    .condi_stop        (condi_stop),
    .done_byte         (done_byte),
    .recieve_bytedata  (recieve_bytedata),
    .ackwaitrequest    (ackwaitrequest),
    .done_ack          (done_ack),
    .send_ackdata      (send_ackdata),
    .recieve_ackdata   (recieve_ackdata),
    .send_bytedata     (send_bytedata),
    .send_bytedatavalid(send_bytedatavalid)
  );

  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_byte = 0, n_ack = 0;

  always @(negedge clock_sig) if (!reset_sig) begin
    if (condi_start) n_start++;
    if (condi_stop)  n_stop++;
    if (done_byte)   n_byte++;
    if (done_ack)    n_ack++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_sig);
  endtask

  task automatic wait_scl();
    int k = 0;
    while (!scl_bus && k < 1000) begin @(negedge clock_sig); k++; end
    chk("scl_released", scl_bus, 1'b1);
  endtask

  task automatic m_start();
    m_sda = 1'b0; cyc(H); m_scl = 1'b0;
  endtask

  task automatic m_bit(input logic b, output logic r);
    cyc(4); m_sda = b; cyc(H - 4);
    m_scl = 1'b1; wait_scl(); cyc(H);
    r = sda_bus; m_scl = 1'b0;
  endtask

  task automatic m_rstart();
    cyc(4); m_sda = 1'b1; cyc(H - 4);
    m_scl = 1'b1; wait_scl(); cyc(H);
    m_sda = 1'b0; cyc(H); m_scl = 1'b0;
  endtask

  task automatic m_stop();
    cyc(4); m_sda = 1'b0; cyc(H - 4);
    m_scl = 1'b1; wait_scl(); cyc(H);
    m_sda = 1'b1; cyc(H);
  endtask

  task automatic m_byte_w(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(v[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_byte_r(output logic [7:0] v, input logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) begin m_bit(1'b1, r); v[i] = r; end
    m_bit(nack, r);
  endtask

  typedef struct {
    logic [7:0] mbyte;
    logic       ackd;
    logic [7:0] exp_byte;
    logic       exp_bus_ack;
    logic       exp_rack;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    logic       ab, r;
    int s0, p0, b0, a0, k, lowc;

    vecs[0] = '{8'hA0, 1'b1, 8'hA0, 1'b0, 1'b1};
    vecs[1] = '{8'h55, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 8'h81, 1'b1, 1'b0};

    cyc(3);
    chk("rst_scl_o", i2c_scl_o, 1'b1);
    chk("rst_sda_o", i2c_sda_o, 1'b1);
    chk("rst_pulses", {condi_start, condi_stop, done_byte, done_ack}, 4'b0000);
    chk("rst_rx_byte", recieve_bytedata, 8'h00);
    chk("rst_rx_ack", recieve_ackdata, 1'b0);
    reset_sig = 1'b0;
    cyc(10);
    chk("idle_no_start", n_start, 0);

    // Single-byte write frames
    for (int i = 0; i < 5; i++) begin
      send_ackdata = vecs[i].ackd;
      s0 = n_start; p0 = n_stop; b0 = n_byte; a0 = n_ack;
      m_start(); m_byte_w(vecs[i].mbyte, ab); m_stop();
      chk($sformatf("vec%0d_done_byte", i), n_byte - b0, 1);
      chk($sformatf("vec%0d_byte", i), recieve_bytedata, vecs[i].exp_byte);
      chk($sformatf("vec%0d_bus_ack", i), ab, vecs[i].exp_bus_ack);
      chk($sformatf("vec%0d_rx_ack", i), recieve_ackdata, vecs[i].exp_rack);
      chk($sformatf("vec%0d_done_ack", i), n_ack - a0, 1);
      chk($sformatf("vec%0d_start", i), n_start - s0, 1);
      chk($sformatf("vec%0d_stop", i), n_stop - p0, 1);
      chk($sformatf("vec%0d_sda_rel", i), i2c_sda_o, 1'b1);
    end

    // Write, repeated START, read one byte, master NACK
    send_ackdata = 1'b1; send_bytedata = 8'h4E;
    s0 = n_start; a0 = n_ack;
    m_start(); m_byte_w(8'hA0, ab);
    chk("rd_addr0_ack", ab, 1'b0);
    m_rstart();
    chk("rd_rstart", n_start - s0, 2);
    send_bytedatavalid = 1'b1;
    m_byte_w(8'hA1, ab);
    chk("rd_addr1_ack", ab, 1'b0);
    cyc(10); send_bytedatavalid = 1'b0;
    m_byte_r(rv, 1'b1);
    chk("rd_master_data", rv, 8'h4E);
    chk("rd_bus_sampled", recieve_bytedata, 8'h4E);
    cyc(10);
    chk("rd_nack", recieve_ackdata, 1'b0);
    chk("rd_sda_rel", i2c_sda_o, 1'b1);
    chk("rd_done_ack", n_ack - a0, 3);
    m_stop();

    // ACK-slot clock stretching
    ackwaitrequest = 1'b1; send_ackdata = 1'b1;
    b0 = n_byte; lowc = 0; k = 0;
    fork
      begin m_start(); m_byte_w(8'h3C, ab); m_stop(); end
      begin
        do begin @(negedge clock_sig); k++; end while (!done_byte && k < 2000);
        chk("str_done_byte", done_byte, 1'b1);
        repeat (50) begin @(negedge clock_sig); if (!i2c_scl_o) lowc++; end
        ackwaitrequest = 1'b0;
        @(negedge clock_sig);
        chk("str_release", i2c_scl_o, 1'b1);
      end
    join
    chk("str_low_cycles", lowc, 50);
    chk("str_byte", recieve_bytedata, 8'h3C);
    chk("str_bus_ack", ab, 1'b0);
    chk("str_rx_ack", recieve_ackdata, 1'b1);
    chk("str_n_byte", n_byte - b0, 1);

    // Short SCL glitch inside a byte must be ignored
    b0 = n_byte;
    m_start();
    for (int i = 7; i >= 4; i--) m_bit(rv[0] | 1'b0 | ((8'h96 >> i) & 8'h01) != 0, r);
    cyc(6); m_scl = 1'b1; cyc(2); m_scl = 1'b0;
    for (int i = 3; i >= 0; i--) m_bit(((8'h96 >> i) & 8'h01) != 0, r);
    m_bit(1'b1, ab);
    m_stop();
    chk("glitch_byte", recieve_bytedata, 8'h96);
    chk("glitch_n_byte", n_byte - b0, 1);
    chk("glitch_ack", ab, 1'b0);

    // STOP after 4 bits, then START interrupting 5 bits
    b0 = n_byte; p0 = n_stop;
    m_start();
    m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b1, r);
    m_stop();
    chk("abort_stop", n_stop - p0, 1);
    chk("abort_no_byte", n_byte - b0, 0);
    chk("abort_sda_rel", i2c_sda_o, 1'b1);
    chk("abort_scl_rel", i2c_scl_o, 1'b1);
    s0 = n_start;
    m_start();
    m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r);
    m_rstart();
    chk("abort_rstart", n_start - s0, 2);
    chk("abort_rs_sda_rel", i2c_sda_o, 1'b1);
    m_byte_w(8'h5A, ab);
    m_stop();
    chk("abort_byte", recieve_bytedata, 8'h5A);
    chk("abort_n_byte", n_byte - b0, 1);

    // Reset while the PHY drives tx bit 0 low
    send_ackdata = 1'b1; send_bytedata = 8'h4E; send_bytedatavalid = 1'b1;
    m_start(); m_byte_w(8'hA1, ab);
    cyc(10); send_bytedatavalid = 1'b0;
    for (int i = 7; i >= 1; i--) begin m_bit(1'b1, r); rv[i] = r; end
    chk("rst_tx_bits", rv[7:1], 7'h27);
    k = 0;
    while (i2c_sda_o && k < 100) begin @(negedge clock_sig); k++; end
    chk("rst_tx_bit0", i2c_sda_o, 1'b0);
    #2 reset_sig = 1'b1;
    #1;
    chk("arst_sda_o", i2c_sda_o, 1'b1);
    chk("arst_scl_o", i2c_scl_o, 1'b1);
    chk("arst_pulses", {condi_start, condi_stop, done_byte, done_ack}, 4'b0000);
    chk("arst_rx_byte", recieve_bytedata, 8'h00);
    chk("arst_rx_ack", recieve_ackdata, 1'b0);
    @(negedge clock_sig);
    m_scl = 1'b1; m_sda = 1'b1;
    cyc(5);
    reset_sig = 1'b0;
    s0 = n_start; p0 = n_stop;
    cyc(30);
    chk("post_rst_no_start", n_start - s0, 0);
    chk("post_rst_no_stop", n_stop - p0, 0);
    chk("post_rst_sda_o", i2c_sda_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/peridot_board_i2c_phy.md
PERIDOT_BOARD_I2C_PHY -- requirements
Module: peridot_board_i2c_phy

Interface
REQ-001 SHALL provide parameters (name, default, meaning): SYNC_STAGES, 2, input synchroniser depth; FILTER_LEN, 3, consecutive equal samples required to accept an SCL/SDA level.
REQ-002 clock_sig  in  1  clock; all logic rising-edge.
REQ-003 reset_sig  in  1  reset, asynchronous, active-high.
REQ-004 i2c_scl_i / i2c_sda_i  in  1  bus levels; i2c_scl_o / i2c_sda_o  out  1  open-drain drive, 0 = pull low, 1 = release.
REQ-005 condi_start / condi_stop  out  1  one-cycle pulse per detected START (incl. repeated) / STOP.
REQ-006 done_byte  out  1  one-cycle pulse at 8th SCL falling edge; recieve_bytedata  out  8  byte sampled MSB-first, valid from done_byte until next done_byte.
REQ-007 ackwaitrequest  in  1  1 = stretch SCL in ACK slot; done_ack  out  1  one-cycle pulse at 9th SCL falling edge.
REQ-008 send_ackdata  in  1  1 = drive ACK low in receive ACK slot; recieve_ackdata  out  1  1 = SDA low at 9th SCL rise, held until next done_ack.
REQ-009 send_bytedata  in  8  next byte to transmit; send_bytedatavalid  in  1  sampled on done_ack cycle, 1 = transmit next byte.

Function
REQ-010 SHALL synchronise and filter SCL/SDA; all edge/condition detection uses filtered levels only.
REQ-011 START = filtered SDA fall while filtered SCL high; STOP = SDA rise while SCL high; each pulses one cycle after filter acceptance.
REQ-012 States: IDLE, DATA (bits 0-7), ACK (bit 8); 4-bit bit counter; tx mode flag.
REQ-013 IDLE -> DATA on START; any state -> DATA with bit counter 0, tx cleared, SDA released, on START.
REQ-014 Any state -> IDLE on STOP; SDA and SCL released same cycle.
REQ-015 DATA: each SCL rise shifts filtered SDA into receive shift register; counter increments on each SCL fall.
REQ-016 8th SCL fall: latch shift register to recieve_bytedata, pulse done_byte, enter ACK.
REQ-017 ACK, rx mode: i2c_sda_o = ~send_ackdata continuously until 9th SCL fall; tx mode: SDA released.
REQ-018 ACK: i2c_scl_o = 0 from cycle after done_byte while ackwaitrequest=1 and SCL low; released when ackwaitrequest=0; never drives SCL elsewhere.
REQ-019 9th SCL rise: recieve_ackdata <= ~filtered SDA; 9th SCL fall: pulse done_ack, counter 0, enter DATA.
REQ-020 On done_ack cycle: send_bytedatavalid=1 -> tx=1, load send_bytedata, drive bit 7 immediately; else tx=0, SDA released.
REQ-021 tx DATA: next bit presented on each SCL fall for bits 6..0; done_byte still pulses (recieve_bytedata = bus-sampled byte).
REQ-022 Simultaneous done_ack and condi_start impossible; START always wins over pending shift/load.
REQ-023 SCL/SDA change after SCL fall is delayed by sync+filter latency (hold time); no other added delay.

Reset
REQ-024 On reset_sig: state IDLE, counter 0, tx 0, shift/recieve_bytedata 8'h00, recieve_ackdata 0, all pulses 0, i2c_scl_o = i2c_sda_o = 1, filter outputs 1.
REQ-025 Reset mid-transfer SHALL release bus within the same asynchronous assertion; no condition pulse on deassertion while bus idle-high.

Structure
REQ-026 State encodings and bit-count limits (8, 9) SHALL live in shared include peridot_board_i2c_defs.
REQ-027 One sub-module peridot_board_i2c_filter (synchroniser + FILTER_LEN stability filter), instantiated for SCL and SDA.
REQ-028 Estimated 150-250 RTL lines; no RAM, no multi-clock.

Verification
REQ-029 Write 0xA0 with send_ackdata=1 -> done_byte, recieve_bytedata=0xA0, SDA low during 9th clock, done_ack, recieve_ackdata=1.
REQ-030 Repeated START, 0xA1, then send_bytedatavalid=1, send_bytedata=0x4E -> master samples 0x4E; master NACK -> recieve_ackdata=0, SDA released.
REQ-031 ackwaitrequest=1 for 50 cycles after done_byte -> SCL held low 50 cycles, master clock resumes after release, no bit lost.
REQ-032 2-cycle glitch on SCL (FILTER_LEN=3) during DATA -> no shift, counter unchanged.
REQ-033 STOP after 4 bits, and START after 5 bits -> IDLE/condi_stop, then counter 0/condi_start; SDA released both cases.
REQ-034 reset_sig asserted while driving tx bit 0 -> i2c_sda_o=1, i2c_scl_o=1 same cycle; all outputs at reset values.
